// File: rtl/word_line_if.sv
// word_line_if: word-side requester and line-side memory signals of the word/line adapter.
interface word_line_if #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_address;
  logic [WORD_W-1:0]     mem_wdata;
  logic [WORD_W/8-1:0]   mem_byte_enable;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  mem_resp;
  logic                  inval;
  logic                  line_read;
  logic                  line_write;
  logic [ADDR_W-1:0]     line_address;
  logic [LINE_W-1:0]     line_wdata;
  logic [LINE_W/8-1:0]   line_byte_enable;
  logic [LINE_W-1:0]     line_rdata;
  logic                  line_resp;
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, inval,
           line_rdata, line_resp,
    input  mem_rdata, mem_resp, line_read, line_write, line_address, line_wdata,
           line_byte_enable
  );
  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, inval,
           line_rdata, line_resp,
    output mem_rdata, mem_resp, line_read, line_write, line_address, line_wdata,
           line_byte_enable
  );
endinterface

// File: rtl/word_line_adapter.sv
// word_line_adapter: registered word-to-line bus adapter with a one-line read buffer.
module word_line_adapter #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  word_line_if.slave bus
);
  localparam int WORDS = LINE_W / WORD_W;
  localparam int WB    = WORD_W / 8;
  localparam int LB    = LINE_W / 8;
  localparam int OFF   = $clog2(LB);
  localparam int LWB   = $clog2(WB);
  localparam int SW    = $clog2(WORDS);
  localparam int TW    = ADDR_W - OFF;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;
  state_t r_state, w_state;

  logic [LINE_W-1:0] r_buf_data, w_buf_data, w_merge_line, r_line_wdata, w_line_wdata;
  logic [TW-1:0]     r_buf_tag, w_buf_tag;
  logic              r_buf_valid, w_buf_valid, r_poison, w_poison;
  logic [ADDR_W-1:0] r_addr, w_addr, r_line_address, w_line_address;
  logic [WORD_W-1:0] r_wdata, w_wdata, r_mem_rdata, w_mem_rdata, w_buf_word, w_req_word, w_merge;
  logic [WB-1:0]     r_be, w_be;
  logic [LB-1:0]     r_line_be, w_line_be, w_be_line;
  logic              r_mem_resp, w_mem_resp, r_line_read, w_line_read, r_line_write, w_line_write;
  logic [TW-1:0]     w_req_tag, w_r_tag;
  logic [SW-1:0]     w_req_wsel, w_r_wsel;
  logic              w_hit_req, w_hit_lat, w_unused;

  assign w_req_tag  = bus.mem_address[ADDR_W-1:OFF];
  assign w_r_tag    = r_addr[ADDR_W-1:OFF];
  assign w_req_wsel = bus.mem_address[OFF-1:LWB];
  assign w_r_wsel   = r_addr[OFF-1:LWB];
  assign w_hit_req  = r_buf_valid && (r_buf_tag == w_req_tag);
  assign w_hit_lat  = r_buf_valid && (r_buf_tag == w_r_tag);
  assign w_req_word = r_buf_data[w_req_wsel*WORD_W +: WORD_W];
  assign w_buf_word = r_buf_data[w_r_wsel*WORD_W +: WORD_W];
  assign w_be_line  = {{(LB-WB){1'b0}}, bus.mem_byte_enable} << (w_req_wsel*WB);
  assign w_unused   = ^{bus.mem_address[LWB-1:0], r_addr[LWB-1:0]};

  always_comb begin
    w_merge = w_buf_word;
    for (int b = 0; b < WB; b++)
      if (r_be[b]) w_merge[b*8 +: 8] = r_wdata[b*8 +: 8];
    w_merge_line = r_buf_data;
    w_merge_line[w_r_wsel*WORD_W +: WORD_W] = w_merge;
  end

  always_comb begin
    w_state        = r_state;
    w_buf_data     = r_buf_data;
    w_buf_tag      = r_buf_tag;
    w_buf_valid    = r_buf_valid && !bus.inval;
    w_poison       = r_poison;
    w_addr         = r_addr;
    w_wdata        = r_wdata;
    w_be           = r_be;
    w_mem_rdata    = r_mem_rdata;
    w_mem_resp     = 1'b0;
    w_line_read    = r_line_read;
    w_line_write   = r_line_write;
    w_line_address = r_line_address;
    w_line_wdata   = r_line_wdata;
    w_line_be      = r_line_be;
    case (r_state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          w_addr  = bus.mem_address;
          w_wdata = bus.mem_wdata;
          w_be    = bus.mem_byte_enable;
        end
        if (bus.mem_write) begin
          w_state        = WRITE;
          w_line_write   = 1'b1;
          w_line_address = {w_req_tag, {OFF{1'b0}}};
          w_line_wdata   = {WORDS{bus.mem_wdata}};
          w_line_be      = w_be_line;
        end else if (bus.mem_read && w_hit_req) begin
          w_state     = RESP;
          w_mem_resp  = 1'b1;
          w_mem_rdata = w_req_word;
        end else if (bus.mem_read) begin
          w_state        = FILL;
          w_poison       = 1'b0;
          w_line_read    = 1'b1;
          w_line_address = {w_req_tag, {OFF{1'b0}}};
        end
      end
      FILL: begin
        w_poison = r_poison || bus.inval;
        if (bus.line_resp) begin
          w_state        = RESP;
          w_buf_data     = bus.line_rdata;
          w_buf_tag      = w_r_tag;
          w_buf_valid    = !(r_poison || bus.inval);
          w_mem_rdata    = bus.line_rdata[w_r_wsel*WORD_W +: WORD_W];
          w_mem_resp     = 1'b1;
          w_line_read    = 1'b0;
          w_line_address = '0;
        end
      end
      WRITE: begin
        if (bus.line_resp) begin
          w_state        = RESP;
          w_buf_data     = w_hit_lat ? w_merge_line : r_buf_data;
          w_mem_rdata    = w_hit_lat ? w_merge : r_mem_rdata;
          w_mem_resp     = 1'b1;
          w_line_write   = 1'b0;
          w_line_address = '0;
          w_line_wdata   = '0;
          w_line_be      = '0;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_buf_data     <= '0;
      r_buf_tag      <= '0;
      r_buf_valid    <= 1'b0;
      r_poison       <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_be           <= '0;
      r_mem_rdata    <= '0;
      r_mem_resp     <= 1'b0;
      r_line_read    <= 1'b0;
      r_line_write   <= 1'b0;
      r_line_address <= '0;
      r_line_wdata   <= '0;
      r_line_be      <= '0;
    end else begin
      r_state        <= w_state;
      r_buf_data     <= w_buf_data;
      r_buf_tag      <= w_buf_tag;
      r_buf_valid    <= w_buf_valid;
      r_poison       <= w_poison;
      r_addr         <= w_addr;
      r_wdata        <= w_wdata;
      r_be           <= w_be;
      r_mem_rdata    <= w_mem_rdata;
      r_mem_resp     <= w_mem_resp;
      r_line_read    <= w_line_read;
      r_line_write   <= w_line_write;
      r_line_address <= w_line_address;
      r_line_wdata   <= w_line_wdata;
      r_line_be      <= w_line_be;
    end
  end

  assign bus.mem_rdata        = r_mem_rdata;
  assign bus.mem_resp         = r_mem_resp;
  assign bus.line_read        = r_line_read;
  assign bus.line_write       = r_line_write;
  assign bus.line_address     = r_line_address;
  assign bus.line_wdata       = r_line_wdata;
  assign bus.line_byte_enable = r_line_be;
endmodule

// File: tb/tb_word_line_adapter.sv
// tb_word_line_adapter: directed checks of the word/line adapter with a hand-driven line memory.
module tb_word_line_adapter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  word_line_if #(.WORD_W(32), .LINE_W(256), .ADDR_W(32)) bus ();
  word_line_adapter #(.WORD_W(32), .LINE_W(256), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s mismatch", tag);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.mem_address = a;
    bus.mem_wdata = d;
    bus.mem_byte_enable = be;
  endtask

  task automatic finish_line();
    bus.line_resp = 1'b1;
    step();
    bus.line_resp = 1'b0;
  endtask

  initial begin
    req(0, 0, 32'h0, 32'h0, 4'h0);
    bus.inval = 1'b0;
    bus.line_resp = 1'b0;
    for (int k = 0; k < 8; k++) bus.line_rdata[k*32 +: 32] = 32'h1111_1111 * k;
    step(); step();
    chk("rst_mem_resp", bus.mem_resp, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    chk("rst_line_read", bus.line_read, 0);
    chk("rst_line_write", bus.line_write, 0);
    chk("rst_line_address", bus.line_address, 0);
    chk("rst_line_wdata", bus.line_wdata, 0);
    chk("rst_line_be", bus.line_byte_enable, 0);
    rst_n = 1'b1;
    step();
    // reset while a fill is outstanding
    req(1, 0, 32'h0000_1024, 0, 0);
    step();
    chk("fill_start_read", bus.line_read, 1);
    chk("fill_start_addr", bus.line_address, 32'h0000_1020);
    req(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midfill_rst_read", bus.line_read, 0);
    chk("midfill_rst_addr", bus.line_address, 0);
    step();
    rst_n = 1'b1;
    step();
    // miss: line_resp three cycles after line_read rises
    req(1, 0, 32'h0000_1024, 0, 0);
    step();
    chk("miss_after_rst_read", bus.line_read, 1);
    chk("miss_resp_early", bus.mem_resp, 0);
    req(0, 0, 0, 0, 0);
    step(); step(); step();
    chk("miss_read_held", bus.line_read, 1);
    chk("miss_resp_wait", bus.mem_resp, 0);
    finish_line();
    chk("miss_resp", bus.mem_resp, 1);
    chk("miss_rdata", bus.mem_rdata, 32'h1111_1111);
    chk("miss_read_drop", bus.line_read, 0);
    chk("miss_addr_drop", bus.line_address, 0);
    step();
    chk("resp_one_cycle", bus.mem_resp, 0);
    // hit
    req(1, 0, 32'h0000_1038, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("hit_resp", bus.mem_resp, 1);
    chk("hit_rdata", bus.mem_rdata, 32'h6666_6666);
    chk("hit_no_line_read", bus.line_read, 0);
    step();
    // write merging into the buffered line
    req(0, 1, 32'h0000_1024, 32'hAABB_CCDD, 4'b0101);
    step();
    req(0, 0, 0, 0, 0);
    chk("wr_line_write", bus.line_write, 1);
    chk("wr_no_line_read", bus.line_read, 0);
    chk("wr_addr", bus.line_address, 32'h0000_1020);
    chk("wr_be", bus.line_byte_enable, 32'h0000_0050);
    chk("wr_wdata", bus.line_wdata, {8{32'hAABB_CCDD}});
    finish_line();
    chk("wr_resp", bus.mem_resp, 1);
    chk("wr_hit_rdata", bus.mem_rdata, 32'h11BB_11DD);
    chk("wr_write_drop", bus.line_write, 0);
    chk("wr_be_drop", bus.line_byte_enable, 0);
    chk("wr_wdata_drop", bus.line_wdata, 0);
    step();
    req(1, 0, 32'h0000_1024, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("merged_hit_resp", bus.mem_resp, 1);
    chk("merged_hit_rdata", bus.mem_rdata, 32'h11BB_11DD);
    step();
    // write to another line leaves the buffer alone
    req(0, 1, 32'h0000_2000, 32'h1234_5678, 4'b1111);
    step();
    req(0, 0, 0, 0, 0);
    chk("wr2_addr", bus.line_address, 32'h0000_2000);
    chk("wr2_be", bus.line_byte_enable, 32'h0000_000F);
    finish_line();
    chk("wr2_resp", bus.mem_resp, 1);
    chk("wr2_rdata_hold", bus.mem_rdata, 32'h11BB_11DD);
    step();
    req(1, 0, 32'h0000_1024, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("after_wr2_hit", bus.mem_resp, 1);
    chk("after_wr2_no_read", bus.line_read, 0);
    chk("after_wr2_rdata", bus.mem_rdata, 32'h11BB_11DD);
    step();
    // inval poisons an in-flight fill
    req(1, 0, 32'h0000_3004, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("inv_fill_read", bus.line_read, 1);
    chk("inv_fill_addr", bus.line_address, 32'h0000_3000);
    bus.inval = 1'b1;
    step();
    bus.inval = 1'b0;
    finish_line();
    chk("inv_fill_resp", bus.mem_resp, 1);
    chk("inv_fill_rdata", bus.mem_rdata, 32'h1111_1111);
    step();
    req(1, 0, 32'h0000_3004, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("post_inv_miss", bus.line_read, 1);
    chk("post_inv_no_resp", bus.mem_resp, 0);
    finish_line();
    chk("refill_resp", bus.mem_resp, 1);
    step();
    req(1, 0, 32'h0000_3008, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("refill_hit", bus.mem_resp, 1);
    chk("refill_hit_rdata", bus.mem_rdata, 32'h2222_2222);
    step();
    // read and write together take the write path
    req(1, 1, 32'h0000_3008, 32'hCAFE_F00D, 4'b1111);
    step();
    req(0, 0, 0, 0, 0);
    chk("rw_line_write", bus.line_write, 1);
    chk("rw_line_read", bus.line_read, 0);
    chk("rw_be", bus.line_byte_enable, 32'h0000_0F00);
    finish_line();
    chk("rw_resp", bus.mem_resp, 1);
    chk("rw_rdata", bus.mem_rdata, 32'hCAFE_F00D);
    step();
    // top-of-address-space line, then tag 0 must not alias
    req(1, 0, 32'hFFFF_FFE4, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("top_addr", bus.line_address, 32'hFFFF_FFE0);
    finish_line();
    chk("top_rdata", bus.mem_rdata, 32'h1111_1111);
    step();
    req(1, 0, 32'hFFFF_FFF8, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("top_hit", bus.mem_resp, 1);
    chk("top_hit_rdata", bus.mem_rdata, 32'h6666_6666);
    step();
    req(1, 0, 32'h0000_0004, 0, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("zero_line_miss", bus.line_read, 1);
    chk("zero_line_addr", bus.line_address, 0);
    finish_line();
    chk("zero_line_resp", bus.mem_resp, 1);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/word_line_adapter.md
# word_line_adapter

Parametrised, registered successor to the combinational word/line bus adapter. It sits between a word-wide requester (CPU port or cache datapath) and a line-wide memory port. It holds a one-line read buffer so that repeated reads to the same line are served without a memory access. Writes go straight through to memory and are merged into the buffer when they target the buffered line.

## Interface

Parameters:
- WORD_W, 32: requester data width in bits; multiple of 8.
- LINE_W, 256: memory line width in bits; power-of-two multiple of WORD_W.
- ADDR_W, 32: byte address width.

Derived constants:
- WORDS = LINE_W/WORD_W.
- WB = WORD_W/8.
- OFF = log2(LINE_W/8), the line byte-offset bits.
- WSEL = address[OFF-1 : log2(WB)], the word select within a line.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- mem_read  in  1  word read request; held until mem_resp.
- mem_write  in  1  word write request; held until mem_resp.
- mem_address  in  ADDR_W  byte address.
- mem_wdata  in  WORD_W  write data.
- mem_byte_enable  in  WB  byte enables for the write.
- mem_rdata  out  WORD_W  read data; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- inval  in  1  invalidates the line buffer.
- line_read  out  1  line read request.
- line_write  out  1  line write request.
- line_address  out  ADDR_W  line-aligned address; low OFF bits are 0.
- line_wdata  out  LINE_W  mem_wdata replicated WORDS times.
- line_byte_enable  out  LINE_W/8  mem_byte_enable shifted to lane WSEL·WB; all other bits 0.
- line_rdata  in  LINE_W  line read data; valid with line_resp.
- line_resp  in  1  memory completion pulse.

## Operation

Internal state: buf_data (LINE_W), buf_tag (ADDR_W-OFF), buf_valid, and latched req_addr, req_wdata, req_be, req_is_write.

States: IDLE, FILL, WRITE, RESP.

IDLE:
- mem_write=1: latch the request, go to WRITE. Write wins if mem_read is also 1; that combination is illegal but defined.
- mem_read=1 and buf_valid=1 and tag match: latch, go to RESP. This is a hit.
- mem_read=1 otherwise: latch, go to FILL. This is a miss.

FILL:
- line_read=1 and line_address={req tag, OFF'b0}.
- On line_resp: buf_data←line_rdata, buf_tag←req tag, buf_valid←1 unless the fill is poisoned (see inval); go to RESP.

WRITE:
- line_write=1, with line_wdata and line_byte_enable formed from the latched request.
- On line_resp: if buf_valid and tag match, merge the enabled bytes into word WSEL of buf_data; go to RESP.

RESP:
- mem_resp=1 for exactly one cycle.
- mem_rdata = buf_data word WSEL for reads. For writes, mem_rdata returns that same word if it hits, otherwise it holds its previous value.
- Go to IDLE.

inval:
- Any cycle: buf_valid←0.
- If asserted while in FILL, the fill in flight is poisoned: data is captured and returned, but buf_valid stays 0.
- inval in the same cycle as a completing fill: inval wins.

Line outputs are registered and are 0 outside FILL/WRITE.

## Timing

- Reset (rst_n=0, asynchronous) gives: state IDLE, buf_valid 0, mem_resp 0, mem_rdata 0, line_read 0, line_write 0, line_address 0, line_wdata 0, line_byte_enable 0.
- Read hit: request seen in cycle N, mem_resp in cycle N+1 (latency 1).
- Miss or write: line_read/line_write asserted from N+1 through the line_resp cycle M; mem_resp at M+1; line_* low at M+1.
- Memory latency is unbounded; the line request is held steady until line_resp.
- line_resp outside FILL/WRITE is ignored.
- Back-to-back requests: a new request can be accepted in the cycle after mem_resp, i.e. one idle cycle between transactions.
- Requester inputs are sampled only in IDLE; changes at other times are ignored.
- Address wrap: the tag compare uses the full ADDR_W-OFF bits, with no aliasing. A top-of-address-space line behaves normally.

## Test plan

- Reset mid-FILL (rst_n low for 1 cycle while line_read=1): all outputs 0 immediately; the next read of the same address misses (line_read reasserted).
- Read miss then hit: read 0x0000_1024 with line_rdata word k = 0x1111_1111·k, line_resp after 3 cycles → mem_rdata 0x1111_1111 (word 1), mem_resp at cycle 5. Read 0x0000_1038 → mem_rdata 0x6666_6666 at N+1, with no line_read.
- Write merge: buffer holds the line above; write 0x0000_1024, wdata 0xAABB_CCDD, be 4'b0101 → line_byte_enable 32'h0000_0050, line_wdata = 8 copies. A subsequent read hit returns 0x11BB_11DD.
- Write to another line (0x0000_2000): the buffer is unchanged; a read of 0x0000_1024 still hits.
- inval during FILL: pulse inval while line_read=1 → the read completes with correct data; the next read of the same line misses.
- Simultaneous mem_read and mem_write: the write path is taken (line_write=1, line_read=0).
